// File: rtl/tcpc_regs_pkg.sv
// ============================================================================
// Module   : tcpc_regs_pkg
// Brief    : Address map, FSM encodings and ALERT bit indices for tcpc_regs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcpc_regs_pkg;

  localparam int ALERT_W = 16;

  localparam logic [7:0] ADDR_VID_L        = 8'h00;
  localparam logic [7:0] ADDR_VID_H        = 8'h01;
  localparam logic [7:0] ADDR_ALERT_L      = 8'h10;
  localparam logic [7:0] ADDR_ALERT_H      = 8'h11;
  localparam logic [7:0] ADDR_ALERT_MASK_L = 8'h12;
  localparam logic [7:0] ADDR_ALERT_MASK_H = 8'h13;
  localparam logic [7:0] ADDR_CC_STATUS    = 8'h1D;
  localparam logic [7:0] ADDR_MSG_HDR_INFO = 8'h2E;
  localparam logic [7:0] ADDR_RX_DETECT    = 8'h2F;
  localparam logic [7:0] ADDR_TRANSMIT     = 8'h50;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

  typedef enum int unsigned {
    ALERT_CC_STATUS     = 0,
    ALERT_PWR_STATUS    = 1,
    ALERT_RX_STATUS     = 2,
    ALERT_RX_HARD_RESET = 3,
    ALERT_TX_FAILED     = 4,
    ALERT_TX_DISCARDED  = 5,
    ALERT_TX_SUCCESS    = 6,
    ALERT_VBUS_ALARM_HI = 7,
    ALERT_VBUS_ALARM_LO = 8,
    ALERT_FAULT         = 9,
    ALERT_RX_BUF_OVF    = 10,
    ALERT_VBUS_SNK_DISC = 11
  } alert_bit_e;

endpackage

`default_nettype wire

// File: rtl/tcpc_alert_reg.sv
// ============================================================================
// Module   : tcpc_alert_reg
// Brief    : 16-bit W1C ALERT register with set priority, mask and ALERT_N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcpc_alert_reg
  import tcpc_regs_pkg::*;
#(
  parameter logic [ALERT_W-1:0] ALERT_MASK_RST = 16'h7FFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ALERT_W-1:0] i_set,
  input  logic [7:0]         i_wdata,
  input  logic               i_clr_l,
  input  logic               i_clr_h,
  input  logic               i_mask_l_we,
  input  logic               i_mask_h_we,
  output logic [ALERT_W-1:0] o_alert,
  output logic [ALERT_W-1:0] o_mask,
  output logic               o_alert_n
);

  logic [ALERT_W-1:0] r_alert;
  logic [ALERT_W-1:0] r_mask;
  logic               r_alert_n;
  logic [ALERT_W-1:0] w_clr;

  always_comb begin
    w_clr = {(i_clr_h ? i_wdata : 8'h00), (i_clr_l ? i_wdata : 8'h00)};
  end

  // OR-ing the set pulses after the clear gives hardware events priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alert   <= '0;
      r_mask    <= ALERT_MASK_RST;
      r_alert_n <= 1'b1;
    end else begin
      r_alert <= (r_alert & ~w_clr) | i_set;
      if (i_mask_l_we) r_mask[7:0]  <= i_wdata;
      if (i_mask_h_we) r_mask[15:8] <= i_wdata;
      r_alert_n <= ~|(r_alert & r_mask);
    end
  end

  assign o_alert   = r_alert;
  assign o_mask    = r_mask;
  assign o_alert_n = r_alert_n;

endmodule

`default_nettype wire

// File: rtl/tcpc_regs.sv
// ============================================================================
// Module   : tcpc_regs
// Brief    : TCPC register bank, responder side of the internal register bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcpc_regs
  import tcpc_regs_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID      = 16'h0451,
  parameter logic [15:0] ALERT_MASK_RST = 16'h7FFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQUEST,
  input  logic        RNW,
  input  logic [7:0]  ADDR,
  input  logic [7:0]  WR_DATA,
  output logic [7:0]  RD_DATA,
  output logic        ACK,
  input  logic [7:0]  CC_STATUS_IN,
  input  logic [15:0] ALERT_SET,
  output logic        ALERT_N,
  output logic [7:0]  MSG_HDR_INFO,
  output logic [7:0]  RX_DETECT,
  output logic [7:0]  TRANSMIT,
  output logic        TRANSMIT_WR
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rnw;
  logic [7:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rd_data;
  logic        r_ack;
  logic        r_transmit_wr;
  logic [7:0]  r_msg_hdr_info;
  logic [7:0]  r_rx_detect;
  logic [7:0]  r_transmit;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_ack_d;
  logic [7:0]  w_rd_mux;
  logic [15:0] w_alert;
  logic [15:0] w_alert_mask;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (REQUEST) w_next_state = ACCESS;
      ACCESS:  w_next_state = DONE;
      DONE:    if (!REQUEST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_wr_en = (r_state == ACCESS) && !r_rnw;
    w_rd_en = (r_state == ACCESS) && r_rnw;
    w_ack_d = (r_state == DONE) && REQUEST;
  end

  // ALERT reads see the register before any same-cycle set pulse lands
  always_comb begin
    case (r_addr)
      ADDR_VID_L:        w_rd_mux = VENDOR_ID[7:0];
      ADDR_VID_H:        w_rd_mux = VENDOR_ID[15:8];
      ADDR_ALERT_L:      w_rd_mux = w_alert[7:0];
      ADDR_ALERT_H:      w_rd_mux = w_alert[15:8];
      ADDR_ALERT_MASK_L: w_rd_mux = w_alert_mask[7:0];
      ADDR_ALERT_MASK_H: w_rd_mux = w_alert_mask[15:8];
      ADDR_CC_STATUS:    w_rd_mux = CC_STATUS_IN;
      ADDR_MSG_HDR_INFO: w_rd_mux = r_msg_hdr_info;
      ADDR_RX_DETECT:    w_rd_mux = r_rx_detect;
      ADDR_TRANSMIT:     w_rd_mux = r_transmit;
      default:           w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rnw          <= 1'b0;
      r_addr         <= 8'h00;
      r_wdata        <= 8'h00;
      r_rd_data      <= 8'h00;
      r_ack          <= 1'b0;
      r_transmit_wr  <= 1'b0;
      r_msg_hdr_info <= 8'h00;
      r_rx_detect    <= 8'h00;
      r_transmit     <= 8'h00;
    end else begin
      if ((r_state == IDLE) && REQUEST) begin
        r_rnw   <= RNW;
        r_addr  <= ADDR;
        r_wdata <= WR_DATA;
      end
      r_ack         <= w_ack_d;
      r_transmit_wr <= w_wr_en && (r_addr == ADDR_TRANSMIT);
      if (w_rd_en) r_rd_data <= w_rd_mux;
      if (w_wr_en) begin
        case (r_addr)
          ADDR_MSG_HDR_INFO: r_msg_hdr_info <= r_wdata;
          ADDR_RX_DETECT:    r_rx_detect    <= r_wdata;
          ADDR_TRANSMIT:     r_transmit     <= r_wdata;
          default:           ;
        endcase
      end
    end
  end

  tcpc_alert_reg #(
    .ALERT_MASK_RST (ALERT_MASK_RST)
  ) u_alert (
    .clk         (CLK),
    .rst         (RESET),
    .i_set       (ALERT_SET),
    .i_wdata     (r_wdata),
    .i_clr_l     (w_wr_en && (r_addr == ADDR_ALERT_L)),
    .i_clr_h     (w_wr_en && (r_addr == ADDR_ALERT_H)),
    .i_mask_l_we (w_wr_en && (r_addr == ADDR_ALERT_MASK_L)),
    .i_mask_h_we (w_wr_en && (r_addr == ADDR_ALERT_MASK_H)),
    .o_alert     (w_alert),
    .o_mask      (w_alert_mask),
    .o_alert_n   (ALERT_N)
  );

  assign RD_DATA      = r_rd_data;
  assign ACK          = r_ack;
  assign TRANSMIT_WR  = r_transmit_wr;
  assign MSG_HDR_INFO = r_msg_hdr_info;
  assign RX_DETECT    = r_rx_detect;
  assign TRANSMIT     = r_transmit;

endmodule

`default_nettype wire

// File: tb/tb_tcpc_regs.sv
// ============================================================================
// Module   : tb_tcpc_regs
// Brief    : Self-checking bench for tcpc_regs: vector table, corner sequences
//            and random transactions against a register-map reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcpc_regs;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQUEST;
  logic        RNW;
  logic [7:0]  ADDR;
  logic [7:0]  WR_DATA;
  logic [7:0]  RD_DATA;
  logic        ACK;
  logic [7:0]  CC_STATUS_IN;
  logic [15:0] ALERT_SET;
  logic        ALERT_N;
  logic [7:0]  MSG_HDR_INFO;
  logic [7:0]  RX_DETECT;
  logic [7:0]  TRANSMIT;
  logic        TRANSMIT_WR;

  tcpc_regs #(
    .VENDOR_ID      (16'h0451),
    .ALERT_MASK_RST (16'h7FFF)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .REQUEST      (REQUEST),
    .RNW          (RNW),
    .ADDR         (ADDR),
    .WR_DATA      (WR_DATA),
    .RD_DATA      (RD_DATA),
    .ACK          (ACK),
    .CC_STATUS_IN (CC_STATUS_IN),
    .ALERT_SET    (ALERT_SET),
    .ALERT_N      (ALERT_N),
    .MSG_HDR_INFO (MSG_HDR_INFO),
    .RX_DETECT    (RX_DETECT),
    .TRANSMIT     (TRANSMIT),
    .TRANSMIT_WR  (TRANSMIT_WR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_pulses = 0;

  always @(negedge CLK) if (TRANSMIT_WR === 1'b1) tx_pulses++;

  // Reference model: the register map as plain variables
  logic [15:0] m_alert, m_mask;
  logic [7:0]  m_msg, m_rxd, m_tx;

  task automatic m_reset();
    m_alert = 16'h0000; m_mask = 16'h7FFF;
    m_msg = 8'h00; m_rxd = 8'h00; m_tx = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a, input logic [7:0] cc);
    case (a)
      8'h00: return 8'h51;
      8'h01: return 8'h04;
      8'h10: return m_alert[7:0];
      8'h11: return m_alert[15:8];
      8'h12: return m_mask[7:0];
      8'h13: return m_mask[15:8];
      8'h1D: return cc;
      8'h2E: return m_msg;
      8'h2F: return m_rxd;
      8'h50: return m_tx;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h10: m_alert[7:0]  = m_alert[7:0]  & ~d;
      8'h11: m_alert[15:8] = m_alert[15:8] & ~d;
      8'h12: m_mask[7:0]   = d;
      8'h13: m_mask[15:8]  = d;
      8'h2E: m_msg = d;
      8'h2F: m_rxd = d;
      8'h50: m_tx  = d;
      default: ;
    endcase
  endtask

  function automatic logic m_alert_n();
    return ((m_alert & m_mask) == 16'h0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("transmit_reg", TRANSMIT, m_tx);
    chk("msg_hdr_info_reg", MSG_HDR_INFO, m_msg);
    chk("rx_detect_reg", RX_DETECT, m_rxd);
    chk("alert_n", ALERT_N, m_alert_n());
  endtask

  // One full four-phase transaction; set_acc pulses ALERT_SET during ACCESS
  task automatic bus(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [15:0] set_acc, input int hold, output logic [7:0] rd);
    int lat;
    int p0;
    logic [7:0] cc;
    logic [7:0] exp_rd;
    logic held;
    @(negedge CLK);
    cc = 8'($urandom);
    CC_STATUS_IN = cc;
    REQUEST = 1'b1; RNW = rnw; ADDR = addr; WR_DATA = wdata;
    p0 = tx_pulses;
    exp_rd = m_read(addr, cc);
    @(negedge CLK);
    ALERT_SET = set_acc;
    RNW = ~rnw; ADDR = 8'($urandom); WR_DATA = 8'($urandom);
    @(negedge CLK);
    ALERT_SET = 16'h0000;
    CC_STATUS_IN = ~cc;
    lat = 2;
    while (ACK !== 1'b1 && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    chk("ack_latency", lat, 3);
    rd = RD_DATA;
    if (rnw) chk("rd_data_model", RD_DATA, exp_rd);
    held = 1'b1;
    repeat (hold) begin
      @(negedge CLK);
      if (ACK !== 1'b1) held = 1'b0;
    end
    if (hold > 0) chk("ack_held", held, 1);
    REQUEST = 1'b0;
    @(negedge CLK);
    chk("ack_fall", ACK, 0);
    if (!rnw) m_write(addr, wdata);
    m_alert = m_alert | set_acc;
    chk("transmit_wr_pulses", tx_pulses - p0, (!rnw && addr == 8'h50) ? 1 : 0);
    chk_state();
  endtask

  task automatic pulse(input logic [15:0] v);
    @(negedge CLK);
    ALERT_SET = v;
    @(negedge CLK);
    ALERT_SET = 16'h0000;
    m_alert = m_alert | v;
    @(negedge CLK);
    chk("alert_n_after_set", ALERT_N, m_alert_n());
  endtask

  typedef struct {
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[15];

  logic [7:0] addr_pool[11] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h1D, 8'h2E, 8'h2F, 8'h50, 8'h77};

  initial begin
    logic [7:0] rd;
    int lat;

    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h51};
    tbl[1]  = '{1'b1, 8'h01, 8'h00, 8'h04};
    tbl[2]  = '{1'b1, 8'h12, 8'h00, 8'hFF};
    tbl[3]  = '{1'b1, 8'h13, 8'h00, 8'h7F};
    tbl[4]  = '{1'b0, 8'h2F, 8'hA5, 8'h00};
    tbl[5]  = '{1'b1, 8'h2F, 8'h00, 8'hA5};
    tbl[6]  = '{1'b0, 8'h50, 8'h03, 8'h00};
    tbl[7]  = '{1'b1, 8'h50, 8'h00, 8'h03};
    tbl[8]  = '{1'b0, 8'h00, 8'hFF, 8'h00};
    tbl[9]  = '{1'b0, 8'h77, 8'h12, 8'h00};
    tbl[10] = '{1'b1, 8'h00, 8'h00, 8'h51};
    tbl[11] = '{1'b1, 8'h77, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h2E, 8'h3C, 8'h00};
    tbl[13] = '{1'b1, 8'h2E, 8'h00, 8'h3C};
    tbl[14] = '{1'b1, 8'h10, 8'h00, 8'h00};

    RESET = 1'b1; REQUEST = 1'b0; RNW = 1'b0; ADDR = 8'h00; WR_DATA = 8'h00;
    CC_STATUS_IN = 8'h00; ALERT_SET = 16'h0000;
    m_reset();
    repeat (3) @(negedge CLK);
    chk("rst_ack", ACK, 0);
    chk("rst_rd_data", RD_DATA, 8'h00);
    chk("rst_transmit_wr", TRANSMIT_WR, 0);
    chk("rst_alert_n", ALERT_N, 1);
    chk("rst_transmit", TRANSMIT, 8'h00);
    chk("rst_msg_hdr_info", MSG_HDR_INFO, 8'h00);
    chk("rst_rx_detect", RX_DETECT, 8'h00);
    RESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bus(tbl[i].rnw, tbl[i].addr, tbl[i].wdata, 16'h0000, 0, rd);
      if (tbl[i].rnw) chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
    end
    chk("vec_transmit_out", TRANSMIT, 8'h03);

    // ALERT set, read, clear
    pulse(16'h0004);
    chk("alert_n_low", ALERT_N, 0);
    bus(1'b1, 8'h10, 8'h00, 16'h0000, 0, rd);
    chk("alert_lo_set", rd, 8'h04);
    bus(1'b0, 8'h10, 8'h04, 16'h0000, 0, rd);
    chk("alert_n_cleared", ALERT_N, 1);
    bus(1'b1, 8'h10, 8'h00, 16'h0000, 0, rd);
    chk("alert_lo_cleared", rd, 8'h00);

    // Same-cycle set and clear: set wins
    bus(1'b0, 8'h10, 8'h04, 16'h0004, 0, rd);
    bus(1'b1, 8'h10, 8'h00, 16'h0000, 0, rd);
    chk("set_wins_over_clear", rd, 8'h04);

    // Read coincident with a set pulse returns pre-update value
    bus(1'b1, 8'h10, 8'h00, 16'h0100, 0, rd);
    chk("read_pre_update", rd, 8'h04);
    bus(1'b1, 8'h11, 8'h00, 16'h0000, 0, rd);
    chk("read_post_update", rd, 8'h01);

    // Masking everything deasserts the interrupt while ALERT stays set
    bus(1'b0, 8'h12, 8'h00, 16'h0000, 0, rd);
    bus(1'b0, 8'h13, 8'h00, 16'h0000, 0, rd);
    chk("alert_n_masked", ALERT_N, 1);

    // Same-value TRANSMIT write with REQUEST held: one access, one pulse
    bus(1'b0, 8'h50, 8'h03, 16'h0000, 10, rd);

    // Reset while in DONE with REQUEST still high
    @(negedge CLK);
    REQUEST = 1'b1; RNW = 1'b1; ADDR = 8'h01; WR_DATA = 8'h00;
    lat = 0;
    while (ACK !== 1'b1 && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    chk("pre_reset_ack", ACK, 1);
    RESET = 1'b1;
    #1;
    m_reset();
    chk("midrst_ack", ACK, 0);
    chk("midrst_rd_data", RD_DATA, 8'h00);
    chk_state();
    @(negedge CLK);
    RESET = 1'b0;
    lat = 0;
    while (ACK !== 1'b1 && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    chk("reserve_ack", ACK, 1);
    chk("reserve_rd_data", RD_DATA, 8'h04);
    REQUEST = 1'b0;
    @(negedge CLK);
    chk("reserve_ack_fall", ACK, 0);
    bus(1'b1, 8'h13, 8'h00, 16'h0000, 0, rd);
    chk("mask_hi_after_reset", rd, 8'h7F);

    // Random transactions against the model
    for (int i = 0; i < 250; i++) begin
      logic [7:0]  a;
      logic [15:0] s;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 10)];
      s = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      if ($urandom_range(0, 4) == 0) pulse(16'($urandom));
      bus(1'($urandom), a, 8'($urandom), s, $urandom_range(0, 2), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/tcpc_regs.md
Name: tcpc_regs

Overview:
- Responder end of the TCPC internal register bus: decodes single-byte read/write transactions from the bus arbiter and acknowledges each one.
- Holds the TCPC register bank, including a write-1-to-clear ALERT register, a mask and control registers.
- Generates the ALERT_N interrupt and a TRANSMIT strobe for the Tx engine.
- Sits between the arbiter (one shared master port) and the Tx/Rx/HReset/tcpm datapaths that consume register contents.

Parameters:
- VENDOR_ID, 16'h0451, value returned at 0x00 (low byte) and 0x01 (high byte); read-only.
- ALERT_MASK_RST, 16'h7FFF, reset value of ALERT_MASK.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQUEST  input  1  transaction request; held high until ACK is seen.
- RNW  input  1  1 = read, 0 = write; sampled with REQUEST.
- ADDR  input  8  register address; sampled with REQUEST.
- WR_DATA  input  8  write data; sampled with REQUEST.
- RD_DATA  output  8  read data; valid while ACK=1 on a read.
- ACK  output  1  transaction acknowledge.
- CC_STATUS_IN  input  8  live CC status from the CC logic; read-only register 0x1D.
- ALERT_SET  input  16  single-cycle hardware event pulses, one per ALERT bit.
- ALERT_N  output  1  active-low interrupt: low when (ALERT & ALERT_MASK) != 0.
- MSG_HDR_INFO  output  8  register 0x2E.
- RX_DETECT  output  8  register 0x2F.
- TRANSMIT  output  8  register 0x50.
- TRANSMIT_WR  output  1  one-cycle pulse when 0x50 is written.

Behaviour:
- Clock and reset: one clock domain. RESET is asynchronous, active-high.
- Reset values:
  - RD_DATA=0, ACK=0, TRANSMIT_WR=0.
  - ALERT=0, ALERT_MASK=ALERT_MASK_RST.
  - MSG_HDR_INFO=0, RX_DETECT=0, TRANSMIT=0.
  - ALERT_N=1.
  - FSM=IDLE.
- Register map:
  - 0x00/0x01 VENDOR_ID: RO.
  - 0x10/0x11 ALERT low/high: W1C.
  - 0x12/0x13 ALERT_MASK low/high: RW.
  - 0x1D CC_STATUS: RO, passthrough of CC_STATUS_IN sampled at the ACCESS cycle.
  - 0x2E MSG_HDR_INFO: RW.
  - 0x2F RX_DETECT: RW.
  - 0x50 TRANSMIT: RW.
- Unmapped addresses: read returns 0x00, write is ignored, ACK is still given. Writes to RO addresses are ignored.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on REQUEST=1, latch RNW/ADDR/WR_DATA and go to ACCESS.
  - ACCESS (1 cycle): perform the write, or load RD_DATA; then go to DONE and register ACK=1. ACK rises 2 cycles after the REQUEST-rise sample edge.
  - DONE: hold ACK=1 and RD_DATA while REQUEST=1. When REQUEST=0, ACK=0 next cycle; return to IDLE.
- Handshake rules:
  - Four-phase: a new transaction is accepted only after ACK has fallen.
  - REQUEST kept high after ACK produces no second access.
  - Address/data changes during ACCESS/DONE are ignored (latched copy used).
- ALERT:
  - Per-bit: next = (ALERT & ~clear_mask) | ALERT_SET.
  - clear_mask = WR_DATA on a W1C write to that byte, else 0.
  - Simultaneous set and clear of the same bit in the same cycle: set wins (bit = 1).
  - Writing 0 bits leaves those bits unchanged.
- ALERT_N: registered, = ~|(ALERT & ALERT_MASK). It updates one cycle after an ALERT or ALERT_MASK change.
- TRANSMIT_WR: pulses exactly one cycle, coincident with the TRANSMIT register update in ACCESS. Rewriting the same value still pulses.
- Read of ALERT in the same cycle as an ALERT_SET pulse returns the pre-update value. The set bit is visible on the next read.
- Reset mid-transaction: immediate return to IDLE with all reset values. An outstanding REQUEST is re-accepted as a new transaction once RESET deasserts.
- Width: all bus data is 8 bits. 16-bit registers are byte-addressed, low byte at the even address. No atomic 16-bit access.

Decomposition:
- Package tcpc_regs_pkg holds:
  - Address constants: ADDR_VID_L, ADDR_VID_H, ADDR_ALERT_L, ADDR_ALERT_H, ADDR_ALERT_MASK_L, ADDR_ALERT_MASK_H, ADDR_CC_STATUS, ADDR_MSG_HDR_INFO, ADDR_RX_DETECT, ADDR_TRANSMIT.
  - FSM state encodings: IDLE, ACCESS, DONE.
  - ALERT bit-index constants.
- One sub-module, tcpc_alert_reg: 16-bit W1C register with set-priority, mask and ALERT_N generation.

Test Plan:
- Reset, then read 0x00 and 0x01 -> RD_DATA=0x51 then 0x04. ACK rises 2 cycles after REQUEST and falls 1 cycle after REQUEST drops.
- Write 0x2F=0xA5, read back -> 0xA5. Write 0x50=0x03 -> TRANSMIT=0x03, TRANSMIT_WR high for exactly 1 cycle.
- ALERT_SET=16'h0004 pulse -> ALERT_N=0 one cycle later, read 0x10 -> 0x04. Write 0x10=0x04 -> ALERT_N=1, read 0x10 -> 0x00.
- Same-cycle ALERT_SET bit 2 and W1C write 0x10=0x04 -> bit 2 remains 1. Write 0x12=0x00 and 0x13=0x00 -> ALERT_N=1 while ALERT nonzero.
- Write 0x00=0xFF and write 0x77=0x12 -> no state change. Read 0x77 -> 0x00 with ACK. Hold REQUEST high 10 cycles after ACK -> only one access performed.
- Assert RESET during DONE with REQUEST high -> ACK=0 immediately, registers at reset values. After RESET drops, the transaction is re-served with ACK.
